edge_pulse_tx: RTL and testbench

EDGE_PULSE_TX -- requirements
Module: edge_pulse_tx

---
 rtl/edge_pulse_pkg.sv | 19 +
 rtl/pulse_down_counter.sv | 32 +++
 rtl/edge_pulse_tx.sv | 176 +++++++++++++++++
 tb/tb_edge_pulse_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge_pulse_tx pulse-train generator:
// FSM state type, default counter width and counter-slot indices.
package edge_pulse_pkg;

    localparam int DEFAULT_CNT_W = 8;

    // Slot indices into the counter bank instantiated by edge_pulse_tx.
    localparam int PHASE_CTR = 0;
    localparam int PULSE_CTR = 1;
    localparam int NUM_CTRS  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is zero.
// Load has priority over decrement; a decrement at zero is ignored so the
// count can never wrap.
import edge_pulse_pkg::*;

module pulse_down_counter #(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Count register: clear on reset, otherwise load or saturating decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/edge_pulse_tx.sv
// Pulse-train transmitter: on a start handshake, emits pulse_count pulses
// of high_cycles high / low_cycles low (zero lengths stretched to one so
// every pulse gives a visible rising edge), then a one-cycle done strobe.
// Optional feature macro: EDGE_PULSE_TX_ABORT_EN adds an abort input that
// ends a train in progress via the DONE state.
//
// Counters hold "cycles remaining minus one" so a phase ends when its
// counter reads zero and no counter ever needs to go below zero.
import edge_pulse_pkg::*;

module edge_pulse_tx #(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [CNT_W-1:0] pulse_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
`ifdef EDGE_PULSE_TX_ABORT_EN
    ,
    input  logic             abort
`endif
);

    // Phase length minus one, treating a requested length of 0 as 1.
    function automatic logic [CNT_W-1:0] span_minus_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : (v - 1'b1);
    endfunction

    state_t           state_reg;
    logic             pulse_out_reg;
    logic             done_reg;
    logic [CNT_W-1:0] high_reg;
    logic [CNT_W-1:0] low_reg;

    logic             abort_hit;

    logic [NUM_CTRS-1:0] ctr_load;
    logic [NUM_CTRS-1:0] ctr_dec;
    logic [NUM_CTRS-1:0] ctr_zero;
    logic [CNT_W-1:0]    ctr_value [NUM_CTRS];

`ifdef EDGE_PULSE_TX_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Phase counter (slot PHASE_CTR) and remaining-pulse counter (slot PULSE_CTR).
    generate
        for (genvar gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
            pulse_down_counter #(
                .CNT_W (CNT_W)
            ) u_ctr (
                .clk        (clk),
                .reset      (reset),
                .load       (ctr_load[gi]),
                .load_value (ctr_value[gi]),
                .dec        (ctr_dec[gi]),
                .zero       (ctr_zero[gi])
            );
        end
    endgenerate

    // Counter control: load phase lengths on phase entry, count down within a phase.
    always_comb begin
        ctr_load             = '0;
        ctr_dec              = '0;
        ctr_value[PHASE_CTR] = '0;
        ctr_value[PULSE_CTR] = '0;
        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    ctr_load[PHASE_CTR]  = 1'b1;
                    ctr_value[PHASE_CTR] = span_minus_one(high_cycles);
                    ctr_load[PULSE_CTR]  = 1'b1;
                    ctr_value[PULSE_CTR] = span_minus_one(pulse_count);
                end
            end
            HIGH: begin
                if (!abort_hit) begin
                    if (ctr_zero[PHASE_CTR]) begin
                        ctr_load[PHASE_CTR]  = 1'b1;
                        ctr_value[PHASE_CTR] = span_minus_one(low_reg);
                    end else begin
                        ctr_dec[PHASE_CTR] = 1'b1;
                    end
                end
            end
            LOW: begin
                if (!abort_hit) begin
                    if (ctr_zero[PHASE_CTR]) begin
                        if (!ctr_zero[PULSE_CTR]) begin
                            ctr_load[PHASE_CTR]  = 1'b1;
                            ctr_value[PHASE_CTR] = span_minus_one(high_reg);
                            ctr_dec[PULSE_CTR]   = 1'b1;
                        end
                    end else begin
                        ctr_dec[PHASE_CTR] = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Main FSM with registered pulse_out and done; parameters captured on acceptance only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pulse_out_reg <= 1'b0;
            done_reg      <= 1'b0;
            high_reg      <= '0;
            low_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start_valid) begin
                        high_reg <= high_cycles;
                        low_reg  <= low_cycles;
                        if (pulse_count != '0) begin
                            state_reg     <= HIGH;
                            pulse_out_reg <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            pulse_out_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort_hit) begin
                        state_reg     <= DONE;
                        pulse_out_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end else if (ctr_zero[PHASE_CTR]) begin
                        state_reg     <= LOW;
                        pulse_out_reg <= 1'b0;
                    end
                end
                LOW: begin
                    if (abort_hit) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (ctr_zero[PHASE_CTR]) begin
                        if (ctr_zero[PULSE_CTR]) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= HIGH;
                            pulse_out_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    pulse_out_reg <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out   = pulse_out_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != IDLE);
    assign start_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_edge_pulse_tx.sv
// Directed self-checking bench for edge_pulse_tx. Each cycle's outputs are
// compared as the 4-bit vector {pulse_out, done, busy, start_ready}.
// Abort scenario compiled only with EDGE_PULSE_TX_ABORT_EN.
module tb_edge_pulse_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic [7:0] pulse_count;
    logic       pulse_out;
    logic       busy;
    logic       done;
`ifdef EDGE_PULSE_TX_ABORT_EN
    logic       abort;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    edge_pulse_tx #(
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_count (pulse_count),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done)
`ifdef EDGE_PULSE_TX_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {pulse_out, done, busy, start_ready};
    endfunction

    // Apply one request in cycle 0 and check every following cycle through
    // the first IDLE cycle. With hold set, start_valid stays high with
    // different values for the whole train.
    task automatic run_train(input string name, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] n, input bit hold);
        int he, le, period, total, rises, dones;
        logic prev;
        logic [3:0] exp;
        he = (h == 0) ? 1 : int'(h);
        le = (l == 0) ? 1 : int'(l);
        period = he + le;
        total = int'(n) * period;
        rises = 0;
        dones = 0;
        prev  = 1'b0;
        high_cycles = h;
        low_cycles  = l;
        pulse_count = n;
        start_valid = 1'b1;
        chk($sformatf("%s_c0", name), {28'd0, outs()}, 32'h1);
        for (int c = 1; c <= total + 2; c++) begin
            tick();
            if (c <= total)
                exp = {(((c - 1) % period) < he), 1'b0, 1'b1, 1'b0};
            else if (c == total + 1)
                exp = 4'b0110;
            else
                exp = 4'b0001;
            chk($sformatf("%s_c%0d", name, c), {28'd0, outs()}, {28'd0, exp});
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
            if (done) dones++;
            // Scramble parameter inputs after acceptance; they must not matter.
            high_cycles = 8'h07;
            low_cycles  = 8'h05;
            pulse_count = 8'h09;
            start_valid = hold && (c < total + 2);
        end
        chk($sformatf("%s_rises", name), rises, int'(n));
        chk($sformatf("%s_dones", name), dones, 1);
        $display("train %s H=%0d L=%0d N=%0d hold=%0d rises=%0d dones=%0d",
                 name, h, l, n, hold, rises, dones);
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        pulse_count = '0;
`ifdef EDGE_PULSE_TX_ABORT_EN
        abort       = 1'b0;
`endif
        tick();
        tick();
        chk("reset_state", {28'd0, outs()}, 32'h1);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", {28'd0, outs()}, 32'h1);

        // Hand-computed: H=2 L=3 N=2 -> high 1-2,6-7; done 11; ready 12.
        run_train("h2l3n2", 8'd2, 8'd3, 8'd2, 1'b0);
        // N=0 -> done at 1, ready at 2, never high.
        run_train("n0", 8'd5, 8'd5, 8'd0, 1'b0);
        // Zero lengths stretched to one cycle each.
        run_train("h0l0n3", 8'd0, 8'd0, 8'd3, 1'b0);
        // start_valid held with new values during the train.
        run_train("hold", 8'd2, 8'd1, 8'd3, 1'b1);
        // Asymmetric lengths.
        run_train("h1l4n2", 8'd1, 8'd4, 8'd2, 1'b0);
        // Full-scale pulse count.
        run_train("n255", 8'd0, 8'd0, 8'd255, 1'b0);

        // Reset during the second HIGH of an N=4 (H=2, L=2) train: cycles 5-6.
        begin
            int dones_seen;
            dones_seen  = 0;
            high_cycles = 8'd2;
            low_cycles  = 8'd2;
            pulse_count = 8'd4;
            start_valid = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                tick();
                start_valid = 1'b0;
                if (done) dones_seen++;
            end
            chk("rst_mid_c5_high", {28'd0, outs()}, 32'hA);
            reset = 1'b1;
            tick();
            chk("rst_mid_c6", {28'd0, outs()}, 32'h1);
            reset = 1'b0;
            for (int c = 7; c <= 16; c++) begin
                tick();
                if (done) dones_seen++;
                chk($sformatf("rst_mid_c%0d", c), {28'd0, outs()}, 32'h1);
            end
            chk("rst_mid_dones", dones_seen, 0);
            $display("reset mid-train dones=%0d", dones_seen);
        end

`ifdef EDGE_PULSE_TX_ABORT_EN
        // Abort during LOW of pulse 1 of N=5 (H=2, L=3): LOW is cycles 3-5.
        begin
            int rises, dones_seen;
            logic prev;
            rises = 0;
            dones_seen = 0;
            prev = 1'b0;
            high_cycles = 8'd2;
            low_cycles  = 8'd3;
            pulse_count = 8'd5;
            start_valid = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                start_valid = 1'b0;
                abort = (c == 3);
                if (c == 4) chk("abort_c4_done", {28'd0, outs()}, 32'h6);
                if (c == 5) chk("abort_c5_idle", {28'd0, outs()}, 32'h1);
                if (pulse_out && !prev) rises++;
                prev = pulse_out;
                if (done) dones_seen++;
            end
            abort = 1'b0;
            chk("abort_rises", rises, 1);
            chk("abort_dones", dones_seen, 1);
            $display("abort train rises=%0d dones=%0d", rises, dones_seen);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
